flappy_game_ctrl: RTL and testbench
===================================

Name: flappy_game_ctrl

Overview:
- Per-frame game sequencer for the flappy renderer: owns bird height/velocity, pipe scroll position, pipe gap heights, score and game state.
- Advances once per frame_tick (one-cycle pulse at frame start, generated at top level from the vsync counter).
- Outputs feed the VGA renderer's bird_coord, pipe_pos, pipe_array0/1 and score inputs directly.

Parameters:
GRAVITY, 1, velocity decrement per frame
FLAP_VEL, 8, velocity loaded on flap (signed, upward positive)
MAX_FALL, 10, velocity floor magnitude (velocity saturates at -MAX_FALL)
SCROLL, 2, pipe_pos increment per frame
PIPE_WRAP, 345, pipe spacing; pipe_pos range 0..PIPE_WRAP-1
Y_START, 240, bird height in IDLE
Y_MAX, 440, bird height ceiling
SCORE_MAX, 19, score saturation value
DEAD_FRAMES, 60, frame ticks in DEAD before restart accepted

Ports:
dclk  in  1  pixel clock, 25 MHz
clr  in  1  reset; asynchronous, active-high
frame_tick  in  1  one-cycle pulse, start of frame
flap  in  1  synchronized button level
bird_coord  out  10  bird height above ground, pixels
pipe_pos  out  9  scroll offset of pipe pair
pipe_array0  out  8  gap reference, incoming pipe
pipe_array1  out  8  gap reference, leading pipe
score  out  5  pipes passed, 0..SCORE_MAX
game_state  out  2  0=IDLE, 1=PLAY, 2=DEAD
game_over  out  1  high in DEAD

Behaviour:
- Reset (clr high, any time, mid-frame included): state IDLE, bird_coord=Y_START, vel=0, pipe_pos=0, pipe_array0=100, pipe_array1=100, score=0, game_over=0, flap latch cleared, LFSR=8'hA5, dead counter=0. All outputs registered.
- Flap edge: register flap, rise = flap & ~flap_d. Rise sets flap_pend. flap_pend clears on the next frame_tick that consumes it. Rise and frame_tick in the same cycle: flap is consumed at that tick.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps every dclk cycle, never all-zero.
- IDLE: outputs held at reset values. A flap rise moves to PLAY next cycle with score=0 and flap_pend=1.
- PLAY, on frame_tick: first evaluate hit on the current registered values.
  - If hit: go to DEAD; outputs frozen; dead counter=0.
  - Else, all updates land 1 cycle after the tick:
    - vel = flap_pend ? FLAP_VEL : max(vel-GRAVITY, -MAX_FALL). Velocity is 6-bit signed.
    - bird_coord = clamp(bird_coord+vel, 0, Y_MAX). Use an 11-bit signed intermediate; no wrap.
    - If pipe_pos+SCROLL >= PIPE_WRAP: pipe_pos = pipe_pos+SCROLL-PIPE_WRAP, pipe_array1 = pipe_array0, pipe_array0 = 40+LFSR[6:0]. Otherwise pipe_pos += SCROLL.
    - If old pipe_pos < 255 and new unwrapped pipe_pos >= 255: score = min(score+1, SCORE_MAX).
- hit (combinational, registered values):
  - bird_coord == 0 (ground), or
  - pipe_pos in 156..254 and (460-bird_coord <= pipe_array0+75 or 500-bird_coord >= pipe_array0+215).
- DEAD:
  - Dead counter increments per frame_tick, saturating at DEAD_FRAMES.
  - Flap rise while counter < DEAD_FRAMES is ignored and does not set flap_pend.
  - Flap rise at DEAD_FRAMES moves to IDLE and reloads all reset values.
- No frame_tick: no state or output change except the LFSR and the flap latch.

Test Plan:
- Reset, then flap rise, then tick → state=1, bird_coord=248, vel=8. Next tick without flap → bird_coord=255 (vel 7).
- No flaps from Y_START → vel saturates at -10, bird_coord clamps to 0, next tick → game_state=2, game_over=1, outputs frozen over 5 further ticks.
- Hold bird in 186..284 with flaps, pipe_array0=100 → pipe_pos passes 254→256, score 0→1, no DEAD. Bird held at 300 while pipe_pos=156 → DEAD on next tick.
- Force pipe_pos=344 → tick gives pipe_pos=1, pipe_array1=old pipe_array0, pipe_array0 in 40..167.
- Score at 19 plus another pass → stays 19. Flap in DEAD before 60 ticks → ignored; after 60 ticks → IDLE with reset values.
- Assert clr mid-PLAY between tick and update → all outputs at reset values immediately. Flap rise coincident with tick → FLAP_VEL applied on that tick.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// Per-frame game sequencer for the flappy renderer: bird height/velocity,
// pipe scroll, pipe gap heights, score and IDLE/PLAY/DEAD state.
module flappy_game_ctrl #(
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = 8,
    parameter int MAX_FALL    = 10,
    parameter int SCROLL      = 2,
    parameter int PIPE_WRAP   = 345,
    parameter int Y_START     = 240,
    parameter int Y_MAX       = 440,
    parameter int SCORE_MAX   = 19,
    parameter int DEAD_FRAMES = 60
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic       flap,
    output logic [9:0] bird_coord,
    output logic [8:0] pipe_pos,
    output logic [7:0] pipe_array0,
    output logic [7:0] pipe_array1,
    output logic [4:0] score,
    output logic [1:0] game_state,
    output logic       game_over
);

    localparam int DW = $clog2(DEAD_FRAMES + 1);

    localparam logic signed [6:0]  VEL_FLAP   = 7'(FLAP_VEL);
    localparam logic signed [6:0]  VEL_GRAV   = 7'(GRAVITY);
    localparam logic signed [6:0]  VEL_FLOOR  = 7'(-MAX_FALL);
    localparam logic signed [10:0] Y_MAX_S    = 11'(Y_MAX);
    localparam logic [9:0]         BIRD_RST   = 10'(Y_START);
    localparam logic [9:0]         SCROLL_W   = 10'(SCROLL);
    localparam logic [9:0]         WRAP_W     = 10'(PIPE_WRAP);
    localparam logic [8:0]         WRAP_9     = 9'(PIPE_WRAP);
    localparam logic [4:0]         SCORE_SAT  = 5'(SCORE_MAX);
    localparam logic [DW-1:0]      DEAD_LIMIT = DW'(DEAD_FRAMES);
    localparam logic [7:0]         GAP_RST    = 8'd100;
    localparam logic [7:0]         LFSR_SEED  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic signed [5:0]  vel, vel_nxt;
    logic [9:0]         bird_nxt;
    logic [8:0]         pipe_nxt;
    logic [7:0]         pa0_nxt, pa1_nxt;
    logic [4:0]         score_nxt;
    logic [DW-1:0]      dead_cnt, dead_nxt;
    logic [7:0]         lfsr, lfsr_nxt;
    logic               flap_d, flap_pend, pend_nxt;

    logic               rise, pend_eff, hit, in_window;
    logic signed [6:0]  vel_ext, vel_dec, vel_sat, vel_new;
    logic signed [10:0] bird_sum;
    logic [9:0]         bird_clamped;
    logic [9:0]         pipe_sum;
    logic [10:0]        top_dist, top_ref, bot_dist, bot_ref;

    assign rise     = flap & ~flap_d;
    assign pend_eff = flap_pend | rise;

    // Collision is judged on the registered values, before this frame's update.
    always_comb begin
        top_dist  = 11'd460 - {1'b0, bird_coord};
        top_ref   = {3'b000, pipe_array0} + 11'd75;
        bot_dist  = 11'd500 - {1'b0, bird_coord};
        bot_ref   = {3'b000, pipe_array0} + 11'd215;
        in_window = (pipe_pos >= 9'd156) && (pipe_pos <= 9'd254);
        hit       = (bird_coord == 10'd0) ||
                    (in_window && ((top_dist <= top_ref) || (bot_dist >= bot_ref)));
    end

    always_comb begin
        vel_ext  = {vel[5], vel};
        vel_dec  = vel_ext - VEL_GRAV;
        vel_sat  = (vel_dec < VEL_FLOOR) ? VEL_FLOOR : vel_dec;
        vel_new  = pend_eff ? VEL_FLAP : vel_sat;
        bird_sum = signed'({1'b0, bird_coord}) + signed'({{4{vel_new[6]}}, vel_new});
        if (bird_sum < 11'sd0) begin
            bird_clamped = '0;
        end else if (bird_sum > Y_MAX_S) begin
            bird_clamped = 10'(Y_MAX);
        end else begin
            bird_clamped = bird_sum[9:0];
        end
        pipe_sum = {1'b0, pipe_pos} + SCROLL_W;
    end

    always_comb begin
        state_nxt = state;
        vel_nxt   = vel;
        bird_nxt  = bird_coord;
        pipe_nxt  = pipe_pos;
        pa0_nxt   = pipe_array0;
        pa1_nxt   = pipe_array1;
        score_nxt = score;
        dead_nxt  = dead_cnt;
        pend_nxt  = flap_pend;
        lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if (lfsr_nxt == 8'h00) begin
            lfsr_nxt = LFSR_SEED;
        end

        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PLAY;
                    score_nxt = '0;
                    pend_nxt  = 1'b1;
                end
            end

            PLAY: begin
                pend_nxt = pend_eff;
                if (frame_tick) begin
                    pend_nxt = 1'b0;
                    if (hit) begin
                        state_nxt = DEAD;
                        dead_nxt  = '0;
                    end else begin
                        vel_nxt  = vel_new[5:0];
                        bird_nxt = bird_clamped;
                        if (pipe_sum >= WRAP_W) begin
                            pipe_nxt = pipe_sum[8:0] - WRAP_9;
                            pa1_nxt  = pipe_array0;
                            pa0_nxt  = 8'd40 + {1'b0, lfsr[6:0]};
                        end else begin
                            pipe_nxt = pipe_sum[8:0];
                        end
                        // Scoring looks at the unwrapped sum so a pass is never missed at the seam.
                        if ((pipe_pos < 9'd255) && (pipe_sum >= 10'd255)) begin
                            score_nxt = (score >= SCORE_SAT) ? SCORE_SAT : score + 5'd1;
                        end
                    end
                end
            end

            DEAD: begin
                pend_nxt = 1'b0;
                if (rise && (dead_cnt == DEAD_LIMIT)) begin
                    state_nxt = IDLE;
                    vel_nxt   = '0;
                    bird_nxt  = BIRD_RST;
                    pipe_nxt  = '0;
                    pa0_nxt   = GAP_RST;
                    pa1_nxt   = GAP_RST;
                    score_nxt = '0;
                    dead_nxt  = '0;
                    lfsr_nxt  = LFSR_SEED;
                end else if (frame_tick && (dead_cnt != DEAD_LIMIT)) begin
                    dead_nxt = dead_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            vel         <= '0;
            bird_coord  <= BIRD_RST;
            pipe_pos    <= '0;
            pipe_array0 <= GAP_RST;
            pipe_array1 <= GAP_RST;
            score       <= '0;
            game_over   <= 1'b0;
            dead_cnt    <= '0;
            flap_d      <= 1'b0;
            flap_pend   <= 1'b0;
            lfsr        <= LFSR_SEED;
        end else begin
            state       <= state_nxt;
            vel         <= vel_nxt;
            bird_coord  <= bird_nxt;
            pipe_pos    <= pipe_nxt;
            pipe_array0 <= pa0_nxt;
            pipe_array1 <= pa1_nxt;
            score       <= score_nxt;
            game_over   <= (state_nxt == DEAD);
            dead_cnt    <= dead_nxt;
            flap_d      <= flap;
            flap_pend   <= pend_nxt;
            lfsr        <= lfsr_nxt;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: entry, flap timing, ground and pipe
// collisions, scroll wrap, score saturation, DEAD hold-off and async clear.
module tb_flappy_game_ctrl;

    logic       dclk = 1'b0;
    logic       clr = 1'b1;
    logic       frame_tick = 1'b0;
    logic       flap = 1'b0;
    logic [9:0] bird_coord;
    logic [8:0] pipe_pos;
    logic [7:0] pipe_array0;
    logic [7:0] pipe_array1;
    logic [4:0] score;
    logic [1:0] game_state;
    logic       game_over;

    int nvec = 0;
    int nerr = 0;

    always #5 dclk = ~dclk;

    flappy_game_ctrl dut (
        .dclk        (dclk),
        .clr         (clr),
        .frame_tick  (frame_tick),
        .flap        (flap),
        .bird_coord  (bird_coord),
        .pipe_pos    (pipe_pos),
        .pipe_array0 (pipe_array0),
        .pipe_array1 (pipe_array1),
        .score       (score),
        .game_state  (game_state),
        .game_over   (game_over)
    );

    task automatic cyc();
        @(posedge dclk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        cyc();
        cyc();
        clr = 1'b0;
        cyc();
    endtask

    task automatic pulse_flap();
        flap = 1'b1;
        cyc();
        flap = 1'b0;
        cyc();
    endtask

    // Optional flap rise ahead of the tick, then one frame_tick pulse.
    task automatic tick(input bit do_flap);
        if (do_flap) pulse_flap();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (game_state !== 2'd0) begin nerr++; $display("FAIL rst_state: got %0d want 0", game_state); end
        nvec++; if (bird_coord !== 10'd240) begin nerr++; $display("FAIL rst_bird: got %0d want 240", bird_coord); end
        nvec++; if (pipe_pos !== 9'd0) begin nerr++; $display("FAIL rst_pipe: got %0d want 0", pipe_pos); end
        nvec++; if (pipe_array0 !== 8'd100) begin nerr++; $display("FAIL rst_pa0: got %0d want 100", pipe_array0); end
        nvec++; if (pipe_array1 !== 8'd100) begin nerr++; $display("FAIL rst_pa1: got %0d want 100", pipe_array1); end
        nvec++; if (score !== 5'd0) begin nerr++; $display("FAIL rst_score: got %0d want 0", score); end
        nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL rst_over: got %0d want 0", game_over); end
    endtask

    task automatic test_flap_entry();
        tick(1'b0);
        tick(1'b0);
        nvec++; if ({game_state, bird_coord, pipe_pos} !== {2'd0, 10'd240, 9'd0}) begin
            nerr++; $display("FAIL idle_hold: got state %0d bird %0d pipe %0d want 0/240/0", game_state, bird_coord, pipe_pos); end
        pulse_flap();
        nvec++; if (game_state !== 2'd1) begin nerr++; $display("FAIL entry_state: got %0d want 1", game_state); end
        nvec++; if (bird_coord !== 10'd240) begin nerr++; $display("FAIL entry_no_move: got %0d want 240", bird_coord); end
        tick(1'b0);
        nvec++; if (bird_coord !== 10'd248) begin nerr++; $display("FAIL first_tick_bird: got %0d want 248", bird_coord); end
        nvec++; if (pipe_pos !== 9'd2) begin nerr++; $display("FAIL first_tick_pipe: got %0d want 2", pipe_pos); end
        tick(1'b0);
        nvec++; if (bird_coord !== 10'd255) begin nerr++; $display("FAIL gravity_bird: got %0d want 255", bird_coord); end
        // Rise in the same cycle as the tick must be consumed by that tick.
        flap = 1'b1;
        frame_tick = 1'b1;
        cyc();
        flap = 1'b0;
        frame_tick = 1'b0;
        cyc();
        nvec++; if (bird_coord !== 10'd263) begin nerr++; $display("FAIL coincident_flap: got %0d want 263", bird_coord); end
        nvec++; if (pipe_pos !== 9'd6) begin nerr++; $display("FAIL coincident_pipe: got %0d want 6", pipe_pos); end
    endtask

    task automatic test_clr_mid_play();
        frame_tick = 1'b1;
        #2;
        clr = 1'b1;
        #1;
        nvec++; if (game_state !== 2'd0) begin nerr++; $display("FAIL clr_state: got %0d want 0", game_state); end
        nvec++; if (bird_coord !== 10'd240) begin nerr++; $display("FAIL clr_bird: got %0d want 240", bird_coord); end
        nvec++; if (pipe_pos !== 9'd0) begin nerr++; $display("FAIL clr_pipe: got %0d want 0", pipe_pos); end
        nvec++; if ({pipe_array0, pipe_array1, score, game_over} !== {8'd100, 8'd100, 5'd0, 1'b0}) begin
            nerr++; $display("FAIL clr_rest: got pa0 %0d pa1 %0d score %0d over %0d want 100/100/0/0",
                             pipe_array0, pipe_array1, score, game_over); end
        cyc();
        frame_tick = 1'b0;
        clr = 1'b0;
        cyc();
        nvec++; if ({game_state, bird_coord} !== {2'd0, 10'd240}) begin
            nerr++; $display("FAIL clr_release: got state %0d bird %0d want 0/240", game_state, bird_coord); end
    endtask

    task automatic test_ground_death();
        pulse_flap();
        for (int t = 1; t <= 43; t++) begin
            tick(1'b0);
            if (t == 17) begin
                nvec++; if (bird_coord !== 10'd240) begin nerr++; $display("FAIL arc_return: got %0d want 240", bird_coord); end
            end
            if (t == 19) begin
                nvec++; if (bird_coord !== 10'd221) begin nerr++; $display("FAIL fall_t19: got %0d want 221", bird_coord); end
            end
            if (t == 20) begin
                nvec++; if (bird_coord !== 10'd211) begin nerr++; $display("FAIL vel_floor: got %0d want 211", bird_coord); end
            end
            if (t == 41) begin
                nvec++; if (bird_coord !== 10'd1) begin nerr++; $display("FAIL fall_t41: got %0d want 1", bird_coord); end
            end
            if (t == 42) begin
                nvec++; if ({game_state, bird_coord} !== {2'd1, 10'd0}) begin
                    nerr++; $display("FAIL ground_clamp: got state %0d bird %0d want 1/0", game_state, bird_coord); end
            end
        end
        nvec++; if ({game_state, game_over} !== {2'd2, 1'b1}) begin
            nerr++; $display("FAIL ground_dead: got state %0d over %0d want 2/1", game_state, game_over); end
        for (int k = 0; k < 5; k++) begin
            tick(1'b0);
            nvec++; if ({game_state, game_over, bird_coord, pipe_pos, score} !== {2'd2, 1'b1, 10'd0, 9'd84, 5'd0}) begin
                nerr++; $display("FAIL dead_frozen: got state %0d bird %0d pipe %0d score %0d want 2/0/84/0",
                                 game_state, bird_coord, pipe_pos, score); end
        end
    endtask

    task automatic test_dead_restart();
        for (int k = 0; k < 54; k++) tick(1'b0);
        pulse_flap();
        nvec++; if (game_state !== 2'd2) begin nerr++; $display("FAIL early_flap_ignored: got %0d want 2", game_state); end
        tick(1'b0);
        pulse_flap();
        nvec++; if ({game_state, game_over} !== {2'd0, 1'b0}) begin
            nerr++; $display("FAIL restart_state: got state %0d over %0d want 0/0", game_state, game_over); end
        nvec++; if ({bird_coord, pipe_pos, pipe_array0, pipe_array1, score} !== {10'd240, 9'd0, 8'd100, 8'd100, 5'd0}) begin
            nerr++; $display("FAIL restart_values: got bird %0d pipe %0d pa0 %0d pa1 %0d score %0d want 240/0/100/100/0",
                             bird_coord, pipe_pos, pipe_array0, pipe_array1, score); end
    endtask

    task automatic test_high_bird_death();
        pulse_flap();
        for (int t = 1; t <= 78; t++) tick((t <= 8) || ((t - 8) % 17 == 0));
        nvec++; if ({game_state, bird_coord, pipe_pos} !== {2'd1, 10'd317, 9'd156}) begin
            nerr++; $display("FAIL high_pre: got state %0d bird %0d pipe %0d want 1/317/156", game_state, bird_coord, pipe_pos); end
        tick(1'b0);
        nvec++; if ({game_state, bird_coord, pipe_pos} !== {2'd2, 10'd317, 9'd156}) begin
            nerr++; $display("FAIL high_hit: got state %0d bird %0d pipe %0d want 2/317/156", game_state, bird_coord, pipe_pos); end
    endtask

    task automatic test_pipe_wrap();
        do_reset();
        pulse_flap();
        for (int t = 1; t <= 173; t++) begin
            tick(t % 17 == 1);
            if (t == 127) begin
                nvec++; if ({pipe_pos, score} !== {9'd254, 5'd0}) begin
                    nerr++; $display("FAIL pre_pass: got pipe %0d score %0d want 254/0", pipe_pos, score); end
            end
            if (t == 128) begin
                nvec++; if ({game_state, pipe_pos, score} !== {2'd1, 9'd256, 5'd1}) begin
                    nerr++; $display("FAIL first_pass: got state %0d pipe %0d score %0d want 1/256/1", game_state, pipe_pos, score); end
            end
            if (t == 172) begin
                nvec++; if ({pipe_pos, pipe_array0} !== {9'd344, 8'd100}) begin
                    nerr++; $display("FAIL pre_wrap: got pipe %0d pa0 %0d want 344/100", pipe_pos, pipe_array0); end
            end
        end
        nvec++; if ({game_state, pipe_pos, pipe_array1, score} !== {2'd1, 9'd1, 8'd100, 5'd1}) begin
            nerr++; $display("FAIL wrap: got state %0d pipe %0d pa1 %0d score %0d want 1/1/100/1",
                             game_state, pipe_pos, pipe_array1, score); end
        nvec++; if ((pipe_array0 < 8'd40) || (pipe_array0 > 8'd167)) begin
            nerr++; $display("FAIL wrap_gap: got %0d want 40..167", pipe_array0); end
    endtask

    // Steers the bird into the current gap; the bench tracks scroll and passes itself.
    task automatic test_score_saturation();
        int pp, old, passes, thr, want;
        pp = 1;
        passes = 1;
        for (int t = 0; t < 5000 && passes < 21; t++) begin
            thr = 322 - int'(pipe_array0);
            old = pp;
            pp = pp + 2;
            if (pp >= 345) pp = pp - 345;
            tick(int'(bird_coord) < thr);
            if (old < 255 && old + 2 >= 255) begin
                passes++;
                want = (passes > 19) ? 19 : passes;
                nvec++; if ({game_state, score} !== {2'd1, 5'(want)}) begin
                    nerr++; $display("FAIL pass_%0d: got state %0d score %0d want 1/%0d", passes, game_state, score, want); end
                nvec++; if (pipe_pos !== 9'(pp)) begin
                    nerr++; $display("FAIL pass_%0d_pipe: got %0d want %0d", passes, pipe_pos, pp); end
            end
            if (game_state !== 2'd1) break;
        end
        nvec++; if (passes < 21) begin nerr++; $display("FAIL sat_budget: got %0d passes want 21", passes); end
        nvec++; if (score !== 5'd19) begin nerr++; $display("FAIL score_sat: got %0d want 19", score); end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_flap_entry();
        test_clr_mid_play();
        test_ground_death();
        test_dead_restart();
        test_high_bird_death();
        test_pipe_wrap();
        test_score_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
